// File: rtl/vga_digit_display.sv
// VGA timing generator with an NDIG-wide row of 3x5 block-glyph decimal digits.
// Digit values are latched once per frame into a shadow register; every output is registered.
module vga_digit_display #(
  parameter int          HACTIVE  = 640,
  parameter int          HFP      = 16,
  parameter int          HPULSE   = 96,
  parameter int          HBP      = 48,
  parameter int          VACTIVE  = 480,
  parameter int          VFP      = 10,
  parameter int          VPULSE   = 2,
  parameter int          VBP      = 29,
  parameter bit          SYNC_POL = 1'b0,
  parameter int          NDIG     = 6,
  parameter int          CELL     = 25,
  parameter int          GAP      = 15,
  parameter int          X0       = 50,
  parameter int          Y0       = 150,
  parameter logic [11:0] FG       = 12'h0F0,
  parameter logic [11:0] BG       = 12'h000
) (
  input  logic              dclk,
  input  logic              clr_n,
  input  logic [4*NDIG-1:0] digits_in,
  output logic              hsync,
  output logic              vsync,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              active,
  output logic              frame_start
);

  localparam int HTOTAL = HPULSE + HBP + HACTIVE + HFP;
  localparam int VTOTAL = VPULSE + VBP + VACTIVE + VFP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int HS     = HPULSE + HBP;
  localparam int VS     = VPULSE + VBP;
  localparam int HEND   = (HS + HACTIVE) % HTOTAL;
  localparam int VEND   = (VS + VACTIVE) % VTOTAL;
  localparam int PITCH  = 3 * CELL + GAP;
  localparam int PW     = (PITCH > 1) ? $clog2(PITCH) : 1;
  localparam int CW     = (CELL > 1) ? $clog2(CELL) : 1;
  localparam int SW     = $clog2(NDIG + 1);

  logic [HW-1:0]     r_hc, w_hc_nxt;
  logic [VW-1:0]     r_vc, w_vc_nxt;
  logic [31:0]       w_hc32, w_vc32, w_hcn32, w_vcn32;
  logic              w_hc_last, w_vc_last;
  logic [4*NDIG-1:0] r_shadow;

  logic              r_hrun, w_hrun;
  logic [SW-1:0]     r_slot, w_slot;
  logic [PW-1:0]     r_pcnt, w_pcnt;
  logic [CW-1:0]     r_cx, w_cx;
  logic [1:0]        r_col, w_col;

  logic              r_vrun, w_vrun;
  logic [CW-1:0]     r_cy, w_cy;
  logic [2:0]        r_row, w_row;

  logic              w_act;
  logic [3:0]        w_dig;
  logic [14:0]       w_pat;
  logic [2:0]        w_rowbits;
  logic              w_bit;
  logic [11:0]       w_rgb;

  logic              r_hsync, r_vsync, r_active, r_fs;
  logic [11:0]       r_rgb;

  function automatic logic [14:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 15'b111_101_101_101_111;
      4'd1:    glyph = 15'b010_110_010_010_111;
      4'd2:    glyph = 15'b111_001_111_100_111;
      4'd3:    glyph = 15'b111_001_111_001_111;
      4'd4:    glyph = 15'b101_101_111_001_001;
      4'd5:    glyph = 15'b111_100_111_001_111;
      4'd6:    glyph = 15'b111_100_111_101_111;
      4'd7:    glyph = 15'b111_001_001_001_001;
      4'd8:    glyph = 15'b111_101_111_101_111;
      4'd9:    glyph = 15'b111_101_111_001_111;
      default: glyph = '0;
    endcase
  endfunction

  assign w_hc_last = (r_hc == HW'(HTOTAL - 1));
  assign w_vc_last = (r_vc == VW'(VTOTAL - 1));
  assign w_hc_nxt  = w_hc_last ? '0 : r_hc + HW'(1);
  assign w_vc_nxt  = !w_hc_last ? r_vc : (w_vc_last ? '0 : r_vc + VW'(1));
  assign w_hc32    = 32'(r_hc);
  assign w_vc32    = 32'(r_vc);
  assign w_hcn32   = 32'(w_hc_nxt);
  assign w_vcn32   = 32'(w_vc_nxt);

  // Horizontal glyph scanner: state always describes the current hc, so it is
  // steered by the upcoming hc value (reload at slot row start, stop at active end).
  always_comb begin
    w_hrun = r_hrun;
    w_slot = r_slot;
    w_pcnt = r_pcnt;
    w_cx   = r_cx;
    w_col  = r_col;
    if (X0 < HACTIVE && w_hcn32 == HS + X0) begin
      w_hrun = 1'b1;
      w_slot = '0;
      w_pcnt = '0;
      w_cx   = '0;
      w_col  = '0;
    end else if (w_hcn32 == HEND) begin
      w_hrun = 1'b0;
    end else if (r_hrun) begin
      if (r_pcnt == PW'(PITCH - 1)) begin
        w_pcnt = '0;
        w_cx   = '0;
        w_col  = '0;
        if (r_slot == SW'(NDIG - 1)) w_hrun = 1'b0;
        else                         w_slot = r_slot + SW'(1);
      end else begin
        w_pcnt = r_pcnt + PW'(1);
        if (r_cx == CW'(CELL - 1)) begin
          w_cx = '0;
          if (r_col != 2'd3) w_col = r_col + 2'd1;
        end else begin
          w_cx = r_cx + CW'(1);
        end
      end
    end
  end

  // Vertical glyph scanner advances once per line.
  always_comb begin
    w_vrun = r_vrun;
    w_cy   = r_cy;
    w_row  = r_row;
    if (w_hc_last) begin
      if (Y0 < VACTIVE && w_vcn32 == VS + Y0) begin
        w_vrun = 1'b1;
        w_cy   = '0;
        w_row  = '0;
      end else if (w_vcn32 == VEND) begin
        w_vrun = 1'b0;
      end else if (r_vrun) begin
        if (r_cy == CW'(CELL - 1)) begin
          w_cy = '0;
          if (r_row == 3'd4) w_vrun = 1'b0;
          else               w_row  = r_row + 3'd1;
        end else begin
          w_cy = r_cy + CW'(1);
        end
      end
    end
  end

  always_comb begin
    w_dig = 4'hF;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (r_slot == SW'(k)) w_dig = r_shadow[4*k +: 4];
    end
    w_pat = glyph(w_dig);
    case (r_row)
      3'd0:    w_rowbits = w_pat[14:12];
      3'd1:    w_rowbits = w_pat[11:9];
      3'd2:    w_rowbits = w_pat[8:6];
      3'd3:    w_rowbits = w_pat[5:3];
      default: w_rowbits = w_pat[2:0];
    endcase
    case (r_col)
      2'd0:    w_bit = w_rowbits[2];
      2'd1:    w_bit = w_rowbits[1];
      2'd2:    w_bit = w_rowbits[0];
      default: w_bit = 1'b0;
    endcase
    w_act = (w_hc32 >= HS) && (w_hc32 < HS + HACTIVE) &&
            (w_vc32 >= VS) && (w_vc32 < VS + VACTIVE);
    w_rgb = '0;
    if (w_act) w_rgb = (r_hrun && r_vrun && w_bit) ? FG : BG;
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      r_hc     <= '0;
      r_vc     <= '0;
      r_shadow <= '1;
      r_hrun   <= 1'b0;
      r_slot   <= '0;
      r_pcnt   <= '0;
      r_cx     <= '0;
      r_col    <= '0;
      r_vrun   <= 1'b0;
      r_cy     <= '0;
      r_row    <= '0;
      r_hsync  <= ~SYNC_POL;
      r_vsync  <= ~SYNC_POL;
      r_active <= 1'b0;
      r_fs     <= 1'b0;
      r_rgb    <= '0;
    end else begin
      r_hc   <= w_hc_nxt;
      r_vc   <= w_vc_nxt;
      if (w_hc_last && w_vc_last) r_shadow <= digits_in;
      r_hrun <= w_hrun;
      r_slot <= w_slot;
      r_pcnt <= w_pcnt;
      r_cx   <= w_cx;
      r_col  <= w_col;
      r_vrun <= w_vrun;
      r_cy   <= w_cy;
      r_row  <= w_row;
      r_hsync  <= (w_hc32 < HPULSE) ? SYNC_POL : ~SYNC_POL;
      r_vsync  <= (w_vc32 < VPULSE) ? SYNC_POL : ~SYNC_POL;
      r_active <= w_act;
      r_fs     <= (r_hc == '0) && (r_vc == '0);
      r_rgb    <= w_rgb;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign red         = r_rgb[11:8];
  assign green       = r_rgb[7:4];
  assign blue        = r_rgb[3:0];
  assign active      = r_active;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_digit_display.sv
// Scoreboarded bench for vga_digit_display on a reduced raster; two builds (both sync polarities).
module tb_vga_digit_display;

  localparam int HA = 40, HF = 2, HP = 4, HB = 3;
  localparam int VA = 30, VF = 2, VP = 2, VB = 3;
  localparam int ND = 6, CL = 2, GP = 1, XO = 3, YO = 5;
  localparam logic [11:0] FGC = 12'h0F0;
  localparam logic [11:0] BGC = 12'h123;
  localparam int HT = HP + HB + HA + HF;
  localparam int VT = VP + VB + VA + VF;
  localparam int HS = HP + HB;
  localparam int VS = VP + VB;
  localparam int PITCH = 3 * CL + GP;
  localparam int FR = HT * VT;

  logic              dclk = 1'b0;
  logic              clr_n = 1'b0;
  logic [4*ND-1:0]   digits_in = '0;
  logic              hs0, vs0, act0, fs0, hs1, vs1, act1, fs1;
  logic [3:0]        r0, g0, b0, r1, g1, b1;

  vga_digit_display #(
    .HACTIVE(HA), .HFP(HF), .HPULSE(HP), .HBP(HB),
    .VACTIVE(VA), .VFP(VF), .VPULSE(VP), .VBP(VB),
    .SYNC_POL(1'b0), .NDIG(ND), .CELL(CL), .GAP(GP), .X0(XO), .Y0(YO),
    .FG(FGC), .BG(BGC)
  ) u_dut0 (
    .dclk(dclk), .clr_n(clr_n), .digits_in(digits_in),
    .hsync(hs0), .vsync(vs0), .red(r0), .green(g0), .blue(b0),
    .active(act0), .frame_start(fs0)
  );

  vga_digit_display #(
    .HACTIVE(HA), .HFP(HF), .HPULSE(HP), .HBP(HB),
    .VACTIVE(VA), .VFP(VF), .VPULSE(VP), .VBP(VB),
    .SYNC_POL(1'b1), .NDIG(ND), .CELL(CL), .GAP(GP), .X0(XO), .Y0(YO),
    .FG(FGC), .BG(BGC)
  ) u_dut1 (
    .dclk(dclk), .clr_n(clr_n), .digits_in(digits_in),
    .hsync(hs1), .vsync(vs1), .red(r1), .green(g1), .blue(b1),
    .active(act1), .frame_start(fs1)
  );

  always #5 dclk = ~dclk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
    logic [11:0] rgb;
  } exp_t;

  exp_t        q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [14:0] GLYPH [16] = '{
    15'b111_101_101_101_111, 15'b010_110_010_010_111, 15'b111_001_111_100_111,
    15'b111_001_111_001_111, 15'b101_101_111_001_001, 15'b111_100_111_001_111,
    15'b111_100_111_101_111, 15'b111_001_001_001_001, 15'b111_101_111_101_111,
    15'b111_101_111_001_111, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0};

  // Reference pixel: straight geometry with division, from raster position to colour.
  function automatic logic [11:0] ref_rgb(input int hc, input int vc, input logic [4*ND-1:0] sh);
    int x, y, s, dx, dy;
    logic [3:0]  d;
    logic [14:0] p;
    x = hc - HS;
    y = vc - VS;
    if (x < 0 || x >= HA || y < 0 || y >= VA) return 12'h000;
    if (x < XO || y < YO || y >= YO + 5 * CL) return BGC;
    s  = (x - XO) / PITCH;
    dx = (x - XO) % PITCH;
    if (s >= ND || dx >= 3 * CL) return BGC;
    d  = sh[4*s +: 4];
    p  = GLYPH[d];
    dy = y - YO;
    return p[14 - (3 * (dy / CL) + dx / CL)] ? FGC : BGC;
  endfunction

  int              m_hc = 0;
  int              m_vc = 0;
  logic [4*ND-1:0] m_sh = '1;

  // Model: one expected output per clock edge, for the raster position before the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge dclk);
      if (!clr_n) begin
        m_hc = 0;
        m_vc = 0;
        m_sh = '1;
        e = '{hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0, rgb: 12'h000};
      end else begin
        e.hs  = (m_hc < HP) ? 1'b0 : 1'b1;
        e.vs  = (m_vc < VP) ? 1'b0 : 1'b1;
        e.act = (m_hc >= HS && m_hc < HS + HA && m_vc >= VS && m_vc < VS + VA);
        e.fs  = (m_hc == 0 && m_vc == 0);
        e.rgb = ref_rgb(m_hc, m_vc, m_sh);
        if (m_hc == HT - 1 && m_vc == VT - 1) m_sh = digits_in;
        if (m_hc == HT - 1) begin
          m_hc = 0;
          m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
        end else begin
          m_hc = m_hc + 1;
        end
      end
      q.push_back(e);
    end
  end

  // Monitor: compare both builds every output cycle, plus per-frame period/active totals.
  initial begin
    exp_t        e;
    logic [15:0] got0, got1, want1;
    int          cyc = 0;
    int          acnt = 0;
    bit          have_prev = 1'b0;
    forever begin
      @(negedge dclk);
      if (q.size() > 0) begin
        e     = q.pop_front();
        got0  = {hs0, vs0, act0, fs0, r0, g0, b0};
        got1  = {hs1, vs1, act1, fs1, r1, g1, b1};
        want1 = {~e.hs, ~e.vs, e.act, e.fs, e.rgb};
        n_vec++;
        if (got0 !== e) begin
          n_err++;
          $display("FAIL pix_pol0 t=%0t got=%h exp=%h", $time, got0, e);
        end
        n_vec++;
        if (got1 !== want1) begin
          n_err++;
          $display("FAIL pix_pol1 t=%0t got=%h exp=%h", $time, got1, want1);
        end
      end
      if (!clr_n) begin
        have_prev = 1'b0;
      end else begin
        if (fs0) begin
          if (have_prev) begin
            n_vec++;
            if (cyc != FR) begin
              n_err++;
              $display("FAIL frame_period got=%0d exp=%0d", cyc, FR);
            end
            n_vec++;
            if (acnt != HA * VA) begin
              n_err++;
              $display("FAIL active_count got=%0d exp=%0d", acnt, HA * VA);
            end
          end
          cyc = 0;
          acnt = 0;
          have_prev = 1'b1;
        end
        cyc++;
        if (act0) acnt++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge dclk);
    #1;
  endtask

  task automatic wait_pos(input int hc, input int vc, input string name);
    int i;
    for (i = 0; i < 2 * FR && !(m_hc == hc && m_vc == vc); i++) cycles(1);
    if (!(m_hc == hc && m_vc == vc)) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_%s got=timeout exp=hc%0d_vc%0d", name, hc, vc);
    end
  endtask

  initial begin
    logic [15:0] rst0, rst1;
    cycles(3);
    clr_n = 1'b1;
    // slot5..slot0 = 9,0,F,A,8,4; slot5 is clipped at the right edge
    digits_in = {4'h9, 4'h0, 4'hF, 4'hA, 4'h8, 4'h4};
    cycles(2 * FR);
    // mid-frame change of slot1 (8 -> 1) partway down the glyph row
    wait_pos(HS + 10, VS + YO + 4, "midframe");
    digits_in[7:4] = 4'h1;
    cycles(2 * FR);
    repeat (6) begin
      cycles($urandom_range(200, FR));
      digits_in = 24'($urandom);
    end
    cycles(FR);
    // asynchronous reset in the middle of the glyph row
    wait_pos(HS + 20, VS + YO + 3, "reset");
    clr_n = 1'b0;
    #1;
    rst0 = {hs0, vs0, act0, fs0, r0, g0, b0};
    rst1 = {hs1, vs1, act1, fs1, r1, g1, b1};
    n_vec++;
    if (rst0 !== 16'hC000) begin
      n_err++;
      $display("FAIL async_reset_pol0 got=%h exp=%h", rst0, 16'hC000);
    end
    n_vec++;
    if (rst1 !== 16'h0000) begin
      n_err++;
      $display("FAIL async_reset_pol1 got=%h exp=%h", rst1, 16'h0000);
    end
    cycles(3);
    clr_n = 1'b1;
    cycles(2 * FR + 5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
